gradlyr1: RTL and testbench
===========================

# gradlyr1

Backward-pass companion to the layer-1 forward MAC in the VAE datapath. Per output position it takes the upstream gradient `delta` and the same 3x3 input window used in the forward pass. It accumulates the weight gradients (delta·d_k) and the bias gradient (delta) over `NPOS` positions using one time-shared fixed-point multiplier, then presents the nine weight gradients and the bias gradient to the weight-update stage through a valid/ready handshake.

## Interface
- `WIDTH`, 16: data/weight/gradient word width, signed two's complement
- `FRAC`, 8: fractional bits (Q8.8 at defaults; 1.0 = 0x0100)
- `ACCW`, 24: accumulator width, signed
- `NPOS`, 676: positions accumulated per batch (26x26 output map)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  sample valid
- `in_ready`  out  1  block can accept a sample
- `delta`  in  WIDTH  output gradient for this position
- `d_win`  in  9*WIDTH  window; d1 at [WIDTH-1:0], d9 at top
- `out_valid`  out  1  gradient set valid
- `out_ready`  in  1  consumer accepts gradient set
- `gw`  out  9*WIDTH  weight gradients; gw1 at [WIDTH-1:0]
- `gb`  out  WIDTH  bias gradient
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `delta` and `d_win`, set k=0, go to MAC.
- MAC (exactly 9 cycles, k=0..8):
  - Each cycle: p = (delta·d_{k+1}) as a 2·WIDTH signed product, shifted right arithmetically by FRAC (truncates toward −inf), sign-extended to ACCW.
  - acc[k] ← sat_ACCW(acc[k] + p).
  - At k=8, also accb ← sat_ACCW(accb + sext(delta)).
  - After k=8: if pos_cnt == NPOS−1, go to OUT; otherwise pos_cnt++ and go to IDLE.
- OUT:
  - `out_valid`=1; `gw[k]` = sat_WIDTH(acc[k]); `gb` = sat_WIDTH(accb).
  - Outputs are stable while `out_ready`=0. `in_ready`=0, and `in_valid` is ignored.
  - On `out_ready`: clear acc[0..8], accb and pos_cnt; go to IDLE.
- Saturation clamps to [−2^(n−1), 2^(n−1)−1]. The ACCW clamp is applied on every accumulate; the WIDTH clamp is applied only on output.
- Reset (any state, including mid-MAC):
  - state=IDLE, every acc, accb, pos_cnt and latch = 0.
  - `out_valid`=0, `in_ready`=1 once `rst` is high, `busy`=0, `gw`=0, `gb`=0.
  - A partially accumulated batch is discarded.

## Timing
- Sample accepted at edge t → MAC during cycles t+1..t+9 → `in_ready` high again at t+10 (non-final sample).
- Throughput: one sample per 10 cycles.
- Final sample accepted at t → `out_valid` asserted at t+10.
- Handshake at edge u → `out_valid`=0 and `in_ready`=1 from u+1.
- `out_ready` held high before OUT is entered: the handshake completes on the first OUT cycle, so `out_valid` is high for exactly one cycle.
- `in_valid` may toggle freely; no sample is lost or double-counted.

## Structure
- Shared package `vae_pkg`:
  - WIDTH, FRAC and ACCW defaults
  - `sat` function, parameterised by target width
  - state enum {IDLE, MAC, OUT}
- Sub-module `grad_mac`: a single multiply/shift/saturating-accumulate datapath slice, time-shared over k. The nine accumulators live in the parent.

## Test plan
- Reset: hold `rst` low with `in_valid`=1 → `out_valid`=0, `busy`=0, `gw`/`gb`=0. After release `in_ready`=1 and no sample is absorbed while `rst` is low.
- NPOS=1, delta=0x0100, d_k=k·0x0100 → gw_k=k·0x0100, gb=0x0100, `out_valid` exactly 10 cycles after accept.
- NPOS=2, two samples delta=0x0080, all d=0x0200 → all gw=0x0200, gb=0x0100.
- Sign/truncation, NPOS=1: delta=0xFF00, d1=0x0001 → gw1=0xFFFF. Saturation, NPOS=4: delta=d=0x7FFF → gw=0x7FFF and gb=0x7FFF. Same with delta=0x8000, d=0x7FFF → gw=0x8000.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 → `gw`/`gb` stable, `in_ready`=0. The next batch result matches a fresh batch.
- Reset mid-batch: NPOS=2, assert `rst` during MAC cycle k=4 of sample 2 → outputs clear. A following full batch yields the same values as scenario 3.

Source files
------------

// File: rtl/vae_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : vae_pkg                                                    |
// | Description : Shared definitions for the VAE datapath: default word,     |
// |               fraction and accumulator widths, the sequencer state       |
// |               encoding and a width-parameterised saturation helper.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package vae_pkg;

    localparam int c_WIDTH = 16;   // data/weight/gradient word, signed
    localparam int c_FRAC  = 8;    // fractional bits (Q8.8)
    localparam int c_ACCW  = 24;   // accumulator width, signed

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    // Clamp a wide signed value into the range of an n-bit signed word.
    // The result stays 64 bits wide; callers size-cast to n bits.
    function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                               input int                 n);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        return x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gradlyr1_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : gradlyr1_if                                                |
// | Description : Sample input and gradient-set output handshake bundle of   |
// |               the layer-1 gradient accumulator.                          |
// |   in_valid/in_ready/delta/d_win : one position sample (d1 at LSBs)       |
// |   out_valid/out_ready/gw/gb     : gradient set (gw1 at LSBs)             |
// |   busy                          : sequencer not idle                     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface gradlyr1_if #(
    parameter int WIDTH = vae_pkg::c_WIDTH
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     delta;
    logic [9*WIDTH-1:0]   d_win;
    logic                 out_valid;
    logic                 out_ready;
    logic [9*WIDTH-1:0]   gw;
    logic [WIDTH-1:0]     gb;
    logic                 busy;

    // Producer/consumer side
    modport master (
        output in_valid, delta, d_win, out_ready,
        input  in_ready, out_valid, gw, gb, busy
    );

    // Gradient block side
    modport slave (
        input  in_valid, delta, d_win, out_ready,
        output in_ready, out_valid, gw, gb, busy
    );
endinterface
`default_nettype wire

// File: rtl/gradlyr1_grad_mac.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : grad_mac                                                   |
// | Description : One multiply / arithmetic-shift / saturating-accumulate    |
// |               slice. Purely combinational; the parent time-shares it     |
// |               over the nine window taps.                                 |
// |   delta, d  : signed WIDTH operands                                      |
// |   acc_in    : current accumulator value (ACCW)                           |
// |   acc_out   : sat_ACCW(acc_in + ((delta*d) >>> FRAC))                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module grad_mac
    import vae_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int FRAC  = c_FRAC,
    parameter int ACCW  = c_ACCW
) (
    input  wire logic signed [WIDTH-1:0] delta,
    input  wire logic signed [WIDTH-1:0] d,
    input  wire logic signed [ACCW-1:0]  acc_in,
    output      logic signed [ACCW-1:0]  acc_out
);

    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [63:0]        w_p;
    logic signed [63:0]        w_sum;

    assign w_prod  = (2*WIDTH)'(delta) * (2*WIDTH)'(d);
    // Arithmetic shift rounds toward minus infinity, then sign-extend.
    assign w_p     = 64'(w_prod >>> FRAC);
    assign w_sum   = 64'(acc_in) + w_p;
    assign acc_out = ACCW'(sat(w_sum, ACCW));

endmodule
`default_nettype wire

// File: rtl/gradlyr1.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : gradlyr1                                                   |
// | Description : Layer-1 backward pass. Accumulates weight gradients        |
// |               delta*d_k and the bias gradient delta over NPOS positions  |
// |               with one shared multiplier (9 cycles per sample), then     |
// |               offers the saturated gradient set on a valid/ready port.   |
// |   clk  : rising-edge clock                                               |
// |   rst  : asynchronous reset, active low                                  |
// |   bus  : gradlyr1_if.slave (sample in, gradient set out, busy)           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module gradlyr1
    import vae_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int FRAC  = c_FRAC,
    parameter int ACCW  = c_ACCW,
    parameter int NPOS  = 676
) (
    input wire logic   clk,
    input wire logic   rst,
    gradlyr1_if.slave  bus
);

    localparam int         c_PCW    = (NPOS > 1) ? $clog2(NPOS) : 1;
    localparam logic [1:0] c_S_IDLE = IDLE;
    localparam logic [1:0] c_S_MAC  = MAC;
    localparam logic [1:0] c_S_OUT  = OUT;

    logic [1:0]              r_state;
    logic [3:0]              r_k;
    logic [c_PCW-1:0]        r_pos;
    logic signed [WIDTH-1:0] r_delta;
    logic signed [WIDTH-1:0] r_d   [9];
    logic signed [ACCW-1:0]  r_acc [9];
    logic signed [ACCW-1:0]  r_accb;

    logic signed [WIDTH-1:0] w_d;
    logic signed [ACCW-1:0]  w_acc_cur;
    logic signed [ACCW-1:0]  w_acc_nxt;
    logic signed [ACCW-1:0]  w_accb_nxt;
    logic                    w_last_k;
    logic                    w_last_pos;

    assign w_d        = r_d[r_k];
    assign w_acc_cur  = r_acc[r_k];
    assign w_accb_nxt = ACCW'(sat(64'(r_accb) + 64'(r_delta), ACCW));
    assign w_last_k   = (r_k == 4'd8);
    assign w_last_pos = (r_pos == c_PCW'(NPOS - 1));

    grad_mac #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ACCW  (ACCW)
    ) u_mac (
        .delta   (r_delta),
        .d       (w_d),
        .acc_in  (w_acc_cur),
        .acc_out (w_acc_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_S_IDLE;
            r_k     <= '0;
            r_pos   <= '0;
            r_delta <= '0;
            r_accb  <= '0;
            for (int i = 0; i < 9; i++) begin
                r_d[i]   <= '0;
                r_acc[i] <= '0;
            end
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    // in_ready is high whenever IDLE and out of reset
                    if (bus.in_valid) begin
                        r_delta <= $signed(bus.delta);
                        for (int i = 0; i < 9; i++)
                            r_d[i] <= $signed(bus.d_win[i*WIDTH +: WIDTH]);
                        r_k     <= '0;
                        r_state <= c_S_MAC;
                    end
                end
                c_S_MAC: begin
                    for (int i = 0; i < 9; i++)
                        if (r_k == 4'(i))
                            r_acc[i] <= w_acc_nxt;
                    if (w_last_k) begin
                        r_accb <= w_accb_nxt;
                        r_k    <= '0;
                        if (w_last_pos) begin
                            r_state <= c_S_OUT;
                        end else begin
                            r_pos   <= r_pos + c_PCW'(1);
                            r_state <= c_S_IDLE;
                        end
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                c_S_OUT: begin
                    if (bus.out_ready) begin
                        r_pos  <= '0;
                        r_accb <= '0;
                        for (int i = 0; i < 9; i++)
                            r_acc[i] <= '0;
                        r_state <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    // Gate with rst so nothing appears acceptable while reset is held.
    assign bus.in_ready  = rst && (r_state == c_S_IDLE);
    assign bus.out_valid = (r_state == c_S_OUT);
    assign bus.busy      = (r_state != c_S_IDLE);
    assign bus.gb        = WIDTH'(sat(64'(r_accb), WIDTH));

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_gw
            assign bus.gw[gi*WIDTH +: WIDTH] = WIDTH'(sat(64'(r_acc[gi]), WIDTH));
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_gradlyr1.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_gradlyr1                                                |
// | Description : Directed self-checking bench for gradlyr1. Three instances |
// |               (NPOS = 1, 2, 4) share clock and reset; each step drives   |
// |               one instance and compares against hand-computed values.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_gradlyr1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gradlyr1_if #(.WIDTH(16)) b1 ();
    gradlyr1_if #(.WIDTH(16)) b2 ();
    gradlyr1_if #(.WIDTH(16)) b4 ();

    gradlyr1 #(.WIDTH(16), .FRAC(8), .ACCW(24), .NPOS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    gradlyr1 #(.WIDTH(16), .FRAC(8), .ACCW(24), .NPOS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));
    gradlyr1 #(.WIDTH(16), .FRAC(8), .ACCW(24), .NPOS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));

    int n_checks = 0;
    int n_errors = 0;

    logic         ir, ov, bz;
    logic [143:0] gw;
    logic [15:0]  gb;
    logic [143:0] win;
    logic [143:0] gw_hold;
    int           cyc;

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [143:0] rep(input logic [15:0] v);
        logic [143:0] r;
        for (int i = 0; i < 9; i++) r[i*16 +: 16] = v;
        return r;
    endfunction

    task automatic set_in(input int w, input logic v, input logic [15:0] dl, input logic [143:0] wn);
        case (w)
            1:       begin b1.in_valid = v; b1.delta = dl; b1.d_win = wn; end
            2:       begin b2.in_valid = v; b2.delta = dl; b2.d_win = wn; end
            default: begin b4.in_valid = v; b4.delta = dl; b4.d_win = wn; end
        endcase
    endtask

    task automatic set_ordy(input int w, input logic r);
        case (w)
            1:       b1.out_ready = r;
            2:       b2.out_ready = r;
            default: b4.out_ready = r;
        endcase
    endtask

    task automatic snap(input int w);
        case (w)
            1:       begin ir = b1.in_ready; ov = b1.out_valid; bz = b1.busy; gw = b1.gw; gb = b1.gb; end
            2:       begin ir = b2.in_ready; ov = b2.out_valid; bz = b2.busy; gw = b2.gw; gb = b2.gb; end
            default: begin ir = b4.in_ready; ov = b4.out_valid; bz = b4.busy; gw = b4.gw; gb = b4.gb; end
        endcase
    endtask

    // Offer one sample; returns 1 time unit after the accepting edge.
    task automatic send(input int w, input logic [15:0] dl, input logic [143:0] wn);
        int n;
        n = 0;
        @(negedge clk);
        set_in(w, 1'b1, dl, wn);
        snap(w);
        while (!ir && n < 30) begin
            @(negedge clk);
            snap(w);
            n++;
        end
        chk("send_ready", ir, 1'b1);
        @(posedge clk);
        #1 set_in(w, 1'b0, 16'h0, 144'h0);
    endtask

    // Called just after an accepting edge t; cyc = index of the first edge
    // (t+cyc) at which out_valid is sampled high. Returns at a negedge.
    task automatic wait_out(input int w, output int c);
        c = 0;
        do begin
            c++;
            @(negedge clk);
            snap(w);
            if (!ov) @(posedge clk);
        end while (!ov && c < 40);
        if (!ov) begin
            n_errors++;
            $error("FAIL out_valid wait expired after %0d cycles", c);
        end
        chk("out_valid_timeout", ov, 1'b1);
    endtask

    task automatic take(input int w);
        set_ordy(w, 1'b1);
        @(posedge clk);
        #1 set_ordy(w, 1'b0);
        snap(w);
        chk("take_ov_low", ov, 1'b0);
        chk("take_in_ready", ir, 1'b1);
    endtask

    initial begin
        // ---------------- reset with in_valid held high ----------------
        rst = 1'b0;
        set_ordy(1, 1'b0); set_ordy(2, 1'b0); set_ordy(4, 1'b0);
        set_in(1, 1'b1, 16'h0100, rep(16'h0100));
        set_in(2, 1'b1, 16'h0100, rep(16'h0100));
        set_in(4, 1'b1, 16'h0100, rep(16'h0100));
        repeat (3) @(posedge clk);
        #1 snap(1);
        chk("rst_out_valid", ov, 1'b0);
        chk("rst_busy", bz, 1'b0);
        chk("rst_gw", gw, 144'h0);
        chk("rst_gb", gb, 16'h0);
        @(negedge clk);
        set_in(1, 1'b0, 16'h0, 144'h0);
        set_in(2, 1'b0, 16'h0, 144'h0);
        set_in(4, 1'b0, 16'h0, 144'h0);
        rst = 1'b1;
        @(posedge clk);
        #1 snap(1);
        chk("post_rst_in_ready", ir, 1'b1);
        chk("post_rst_busy", bz, 1'b0);

        // ---------------- NPOS=1 identity: gw_k = d_k ----------------
        for (int k = 1; k <= 9; k++) win[(k-1)*16 +: 16] = 16'(k * 256);
        send(1, 16'h0100, win);
        #0 snap(1);
        chk("s1_busy_after_accept", bz, 1'b1);
        wait_out(1, cyc);
        chk("s1_latency", cyc, 10);
        chk("s1_gw", gw, win);
        chk("s1_gb", gb, 16'h0100);
        take(1);

        // ---------------- NPOS=2 two samples ----------------
        send(2, 16'h0080, rep(16'h0200));
        send(2, 16'h0080, rep(16'h0200));
        wait_out(2, cyc);
        chk("s2_latency", cyc, 10);
        chk("s2_gw", gw, rep(16'h0200));
        chk("s2_gb", gb, 16'h0100);
        take(2);

        // ---------------- sign / truncation toward -inf ----------------
        send(1, 16'hFF00, 144'h1);
        wait_out(1, cyc);
        chk("sign_gw", gw, 144'hFFFF);
        chk("sign_gb", gb, 16'hFF00);
        take(1);

        // ---------------- saturation, positive ----------------
        for (int i = 0; i < 4; i++) send(4, 16'h7FFF, rep(16'h7FFF));
        wait_out(4, cyc);
        chk("satp_gw", gw, rep(16'h7FFF));
        chk("satp_gb", gb, 16'h7FFF);
        take(4);

        // ---------------- saturation, negative ----------------
        for (int i = 0; i < 4; i++) send(4, 16'h8000, rep(16'h7FFF));
        wait_out(4, cyc);
        chk("satn_gw", gw, rep(16'h8000));
        chk("satn_gb", gb, 16'h8000);
        take(4);

        // ---------------- backpressure ----------------
        send(1, 16'h0180, rep(16'h0100));
        wait_out(1, cyc);
        chk("bp_gw", gw, rep(16'h0180));
        chk("bp_gb", gb, 16'h0180);
        gw_hold = gw;
        set_in(1, 1'b1, 16'h0180, rep(16'h0100));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            snap(1);
            chk("bp_gw_stable", gw, gw_hold);
            chk("bp_gb_stable", gb, 16'h0180);
            chk("bp_in_ready_low", ir, 1'b0);
            chk("bp_out_valid_high", ov, 1'b1);
        end
        set_ordy(1, 1'b1);
        @(posedge clk);
        #1 set_ordy(1, 1'b0);
        snap(1);
        chk("bp_hs_ov_low", ov, 1'b0);
        chk("bp_hs_in_ready", ir, 1'b1);
        @(posedge clk);
        #1 set_in(1, 1'b0, 16'h0, 144'h0);
        snap(1);
        chk("bp_next_accepted", bz, 1'b1);
        wait_out(1, cyc);
        chk("bp_next_latency", cyc, 10);
        chk("bp_next_gw", gw, rep(16'h0180));
        chk("bp_next_gb", gb, 16'h0180);
        take(1);

        // ---------------- reset during MAC k=4 of sample 2 ----------------
        send(2, 16'h0080, rep(16'h0200));
        send(2, 16'h0080, rep(16'h0200));
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1 snap(2);
        chk("mid_rst_busy", bz, 1'b0);
        chk("mid_rst_ov", ov, 1'b0);
        chk("mid_rst_gw", gw, 144'h0);
        chk("mid_rst_gb", gb, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        send(2, 16'h0080, rep(16'h0200));
        send(2, 16'h0080, rep(16'h0200));
        wait_out(2, cyc);
        chk("after_rst_gw", gw, rep(16'h0200));
        chk("after_rst_gb", gb, 16'h0100);
        take(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
